// File: rtl/blake512_pkg.sv
// Shared BLAKE-512 constants, padding words and padder state encoding.
`timescale 1ns/1ps
package blake512_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DRAIN   = 2'd2
   } state_e;

   localparam int NWORDS = 16;

   localparam logic [7:0][63:0] IV512 = {
      64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B,
      64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
      64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B,
      64'hBB67AE8584CAA73B, 64'h6A09E667F3BCC908
   };

   localparam logic [15:0][63:0] CB512 = {
      64'h636920D871574E69, 64'h0801F2E2858EFC16,
      64'h24A19947B3916CF7, 64'hBA7C9045F12C7F99,
      64'hB8E1AFED6A267E96, 64'h2FFD72DBD01ADFB7,
      64'hD1310BA698DFB5AC, 64'h9216D5D98979FB1B,
      64'h3F84D5B5B5470917, 64'hC0AC29B7C97C50DD,
      64'hBE5466CF34E90C6C, 64'h452821E638D01377,
      64'h082EFA98EC4E6C89, 64'hA4093822299F31D0,
      64'h13198A2E03707344, 64'h243F6A8885A308D3
   };

   // Word 13 carries the trailing '1' bit that BLAKE-512 puts before the length.
   localparam logic [63:0] PAD_W10 = 64'h8000000000000000;
   localparam logic [63:0] PAD_W11 = 64'h0000000000000000;
   localparam logic [63:0] PAD_W12 = 64'h0000000000000000;
   localparam logic [63:0] PAD_W13 = 64'h0000000000000001;
   localparam logic [63:0] PAD_W14 = 64'h0000000000000000;

   function automatic logic [63:0] len_word(input int unsigned bits);
      return 64'(bits);
   endfunction

endpackage

// File: rtl/blake512_padder.sv
// Collects a fixed-length message into one padded BLAKE-512 block,
// flagging framing errors and draining malformed frames.
`timescale 1ns/1ps
module blake512_padder
   import blake512_pkg::*;
#(
   parameter int MSG_WORDS = 10,
   parameter int LEN_BITS  = 640
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [63:0]   in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic [1023:0] padded_block,
   output logic          block_valid,
   input  logic          block_ready,
   output logic          len_err
);

   localparam logic [3:0] LAST_IDX = 4'(MSG_WORDS - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [63:0] store_q [NWORDS];
   logic        in_ready_q;
   logic        block_valid_q;
   logic        len_err_q;
   logic        accept;

   assign accept = in_valid && in_ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_COLLECT;
         cnt_q         <= '0;
         in_ready_q    <= 1'b1;
         block_valid_q <= 1'b0;
         len_err_q     <= 1'b0;
         for (int i = 0; i < NWORDS; i++) begin
            store_q[i] <= '0;
         end
      end else begin
         len_err_q <= 1'b0;
         unique case (state_q)
            ST_COLLECT: begin
               if (accept) begin
                  if (cnt_q == LAST_IDX) begin
                     cnt_q <= '0;
                     if (in_last) begin
                        store_q[cnt_q] <= in_data;
                        store_q[10]    <= PAD_W10;
                        store_q[11]    <= PAD_W11;
                        store_q[12]    <= PAD_W12;
                        store_q[13]    <= PAD_W13;
                        store_q[14]    <= PAD_W14;
                        store_q[15]    <= len_word(LEN_BITS);
                        state_q        <= ST_HOLD;
                        in_ready_q     <= 1'b0;
                        block_valid_q  <= 1'b1;
                     end else begin
                        // Frame ran long: skip words up to its last marker.
                        len_err_q <= 1'b1;
                        state_q   <= ST_DRAIN;
                     end
                  end else if (in_last) begin
                     len_err_q <= 1'b1;
                     cnt_q     <= '0;
                  end else begin
                     store_q[cnt_q] <= in_data;
                     cnt_q          <= cnt_q + 4'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (block_ready) begin
                  state_q       <= ST_COLLECT;
                  in_ready_q    <= 1'b1;
                  block_valid_q <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (accept && in_last) begin
                  state_q <= ST_COLLECT;
               end
            end
            default: begin
               state_q       <= ST_COLLECT;
               cnt_q         <= '0;
               in_ready_q    <= 1'b1;
               block_valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      padded_block = '0;
      for (int i = 0; i < NWORDS; i++) begin
         padded_block[1023 - 64*i -: 64] = store_q[i];
      end
   end

   assign in_ready    = in_ready_q;
   assign block_valid = block_valid_q;
   assign len_err     = len_err_q;

endmodule

// File: tb/tb_blake512_padder.sv
// Scoreboard bench for blake512_padder: driver queues expected blocks
// and framing errors, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_blake512_padder;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [63:0]   in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic [1023:0] padded_block;
   logic          block_valid;
   logic          block_ready = 1'b1;
   logic          len_err;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [1023:0] exp_q [$];
   int            err_q [$];
   logic [1023:0] mon_e;
   logic [1023:0] cap;
   logic          le_prev = 1'b0;

   blake512_padder #(.MSG_WORDS(10), .LEN_BITS(640)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .padded_block (padded_block),
      .block_valid  (block_valid),
      .block_ready  (block_ready),
      .len_err      (len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   function automatic logic [1023:0] mk_block(input logic [63:0] base);
      logic [1023:0] b;
      b = '0;
      for (int i = 0; i < 10; i++) begin
         b[1023 - 64*i -: 64] = base + 64'(i);
      end
      b[383 -: 64] = 64'h8000000000000000;
      b[191 -: 64] = 64'h0000000000000001;
      b[63 -: 64]  = 64'h0000000000000280;
      return b;
   endfunction

   // Monitor: a handshake visible at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (!rst) begin
         if (block_valid && block_ready) begin
            chk("blk_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               for (int i = 0; i < 16; i++) begin
                  chk($sformatf("blk_w%0d", i),
                      padded_block[1023 - 64*i -: 64],
                      mon_e[1023 - 64*i -: 64]);
               end
            end
         end
         if (len_err) begin
            chk("err_expected", 64'(err_q.size() > 0), 64'd1);
            if (err_q.size() > 0) void'(err_q.pop_front());
            chk("err_pulse_width", {63'b0, le_prev}, 64'd0);
            chk("err_no_block", {63'b0, block_valid}, 64'd0);
         end
      end
      le_prev = len_err;
   end

   task automatic send_word(input logic [63:0] d, input logic last);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 100) chk("in_ready_wait", {63'b0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [63:0] base, input int n,
                             input int last_idx, input int err_idx);
      bit clean;
      clean = (err_idx < 0) && (last_idx == n - 1);
      for (int i = 0; i < n; i++) begin
         if (i == err_idx) err_q.push_back(i);
         if (clean && i == n - 1) begin
            chk("pre_last_bv", {63'b0, block_valid}, 64'd0);
            exp_q.push_back(mk_block(base));
         end
         send_word(base + 64'(i), i == last_idx);
      end
      if (clean) chk("latency_bv", {63'b0, block_valid}, 64'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_bv", {63'b0, block_valid}, 64'd0);
      chk("rst_len_err", {63'b0, len_err}, 64'd0);
      chk("rst_pb_zero", {63'b0, |padded_block}, 64'd0);

      send_frame(64'h0, 10, 9, -1);
      idle(3);

      block_ready = 1'b0;
      send_frame(64'h100, 10, 9, -1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      cap = padded_block;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_bv", {63'b0, block_valid}, 64'd1);
         chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
         chk("bp_stable", {63'b0, padded_block == cap}, 64'd1);
      end
      block_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_ready", {63'b0, in_ready}, 64'd1);
      chk("bp_release_bv", {63'b0, block_valid}, 64'd0);
      idle(2);

      send_frame(64'h200, 5, 4, 4);
      idle(3);
      chk("early_no_bv", {63'b0, block_valid}, 64'd0);
      send_frame(64'h210, 10, 9, -1);
      idle(3);

      send_frame(64'h300, 12, 11, 9);
      idle(2);
      chk("drain_exit_ready", {63'b0, in_ready}, 64'd1);
      send_frame(64'h320, 10, 9, -1);
      idle(3);

      send_frame(64'h400, 6, -1, -1);
      in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      chk("midrst_pb_zero", {63'b0, |padded_block}, 64'd0);
      chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("midrst_bv", {63'b0, block_valid}, 64'd0);
      send_frame(64'h410, 10, 9, -1);
      idle(3);

      block_ready = 1'b1;
      send_frame(64'h500, 10, 9, -1);
      send_frame(64'h600, 10, 9, -1);
      idle(3);

      for (int t = 0; t < 50; t++) begin
         if (exp_q.size() == 0 && err_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk("blocks_outstanding", 64'(exp_q.size()), 64'd0);
      chk("errors_outstanding", 64'(err_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/blake512_padder.md
BLAKE512_PADDER -- requirements
Module: blake512_padder

Interface
REQ-001 SHALL have parameter MSG_WORDS, default 10, meaning the number of 64-bit message words per block (fixed 640-bit message).
REQ-002 SHALL have parameter LEN_BITS, default 640, meaning the message bit length written into the length field.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, 64, message word, big-endian (byte 0 in [63:56]).
REQ-006 SHALL have port in_valid, input, 1, in_data qualifier.
REQ-007 SHALL have port in_last, input, 1, final message word marker, qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1, padder accepts in_data.
REQ-009 SHALL have port padded_block, output, 1024, padded block with word 0 in [1023:960].
REQ-010 SHALL have port block_valid, output, 1, padded_block holds a complete block.
REQ-011 SHALL have port block_ready, input, 1, the hash controller accepts the block and asserts init_round in the same cycle.
REQ-012 SHALL have port len_err, output, 1, one-cycle pulse on a framing error.

Function
REQ-013 SHALL accept a word only on clk edges where in_valid && in_ready are both high.
REQ-014 SHALL implement FSM states COLLECT, HOLD and DRAIN.
REQ-015 COLLECT: in_ready=1; store each accepted word at index word_cnt (0..MSG_WORDS-1); increment word_cnt.
REQ-016 COLLECT, accept with word_cnt==MSG_WORDS-1 and in_last=1: store word, write padding, go to HOLD, reset word_cnt to 0.
REQ-017 Padding SHALL be: word10=0x8000000000000000, words 11-12=0, word13=0x0000000000000001, word14=0, word15=LEN_BITS (0x280).
REQ-018 Latency: block_valid SHALL rise on the cycle after the final word is accepted.
REQ-019 HOLD: in_ready=0; block_valid=1; padded_block SHALL be stable; leave HOLD for COLLECT on block_valid && block_ready.
REQ-020 HOLD with block_ready held low: SHALL remain in HOLD indefinitely with no data change.
REQ-021 COLLECT, accept with in_last=1 and word_cnt<MSG_WORDS-1 (early last): pulse len_err; discard partial data; clear word_cnt; stay in COLLECT.
REQ-022 COLLECT, accept with word_cnt==MSG_WORDS-1 and in_last=0 (missing last): pulse len_err; clear word_cnt; go to DRAIN.
REQ-023 DRAIN: in_ready=1; discard words; return to COLLECT on the cycle after an accepted word with in_last=1.
REQ-024 block_valid SHALL never assert for an errored frame.
REQ-025 The block_ready input SHALL be ignored outside HOLD.

Reset
REQ-026 rst high at a clock edge SHALL force state COLLECT and word_cnt=0.
REQ-027 rst SHALL also clear in the same edge: block_valid=0, len_err=0, padded_block=0.
REQ-028 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-029 rst asserted mid-COLLECT, in HOLD or in DRAIN SHALL abandon the frame without emitting len_err.

Structure
REQ-030 SHALL place IV512, CB constants, padding words and state encodings in the shared package blake512_pkg.
REQ-031 SHALL be a single module with no sub-modules; the word store is a 16x64 register array.

Verification
REQ-032 Nominal: words 0x0000000000000000..0x0000000000000009 with in_last on word 9 -> block_valid next cycle; word10=0x8000000000000000, word13=0x1, word15=0x280.
REQ-033 Backpressure: block_ready low 5 cycles -> block_valid held, padded_block stable, in_ready=0; accepted on cycle 6, in_ready=1 next cycle.
REQ-034 Early last: in_last on word 4 -> len_err 1 cycle, no block_valid; next clean 10-word frame produces a correct block.
REQ-035 Missing last: 12 words, in_last on word 12 -> len_err after word 10 (index 9), words 11-12 dropped, then a clean frame succeeds.
REQ-036 Reset: rst after 6 words -> no block_valid, no len_err; next 10-word frame produces a correct block.
REQ-037 Back-to-back: two frames, block_ready tied high -> two blocks with the second frame's data; in_valid held high throughout.
